// File: rtl/bram_pkg.sv
// Shared types and the bit-masked word merge helper for the true-dual-port RAM.
package bram_pkg;

    // Widest word the merge helper handles. Narrower instances zero-extend
    // into it and truncate the result back to their own width.
    localparam int MERGE_W = 1024;

    typedef enum logic [1:0] {
        RDW_WRITE_FIRST = 2'd0,
        RDW_READ_FIRST  = 2'd1,
        RDW_NO_CHANGE   = 2'd2
    } rdw_mode_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } bram_state_e;

    // Bits with wem=1 take the new data, all other bits keep the old word.
    function automatic logic [MERGE_W-1:0] merge_word(
        input logic [MERGE_W-1:0] old_word,
        input logic [MERGE_W-1:0] d_word,
        input logic [MERGE_W-1:0] wem_word
    );
        return (old_word & ~wem_word) | (d_word & wem_word);
    endfunction

endpackage

// File: rtl/bram_out_stage.sv
// Optional output pipeline register for one RAM read port.
// With OUT_REG=0 the array-side register drives the port directly.
module bram_out_stage
    import bram_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int OUT_REG = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] pipe_r;

    // Free-running extra stage; cleared with the rest of the read path on RST.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pipe_r <= {WIDTH{1'b0}};
        end else begin
            pipe_r <= d;
        end
    end

    assign q = (OUT_REG != 32'sd0) ? pipe_r : d;

endmodule

// File: rtl/bram_tdp_param.sv
// Parametrised true-dual-port block RAM with per-bit write mask, selectable
// read-during-write behaviour, optional output register, post-reset clear
// sequencer and a defined same-address collision policy (port 0 wins).
module bram_tdp_param
    import bram_pkg::*;
#(
    parameter int        DEPTH        = 2048,
    parameter int        WIDTH        = 8,
    parameter int        OUT_REG      = 0,
    parameter rdw_mode_e RDW_MODE     = RDW_WRITE_FIRST,
    parameter int        CLEAR_ON_RST = 1,
    localparam int       AW           = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [AW-1:0]    A0,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] WEM0,
    input  logic             WE0,
    input  logic             CE0,
    output logic [WIDTH-1:0] Q0,
    input  logic [AW-1:0]    A1,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] WEM1,
    input  logic             WE1,
    input  logic             CE1,
    output logic [WIDTH-1:0] Q1,
    output logic             INIT_DONE,
    output logic             COLL
);

    // One extra bit so DEPTH itself is representable for power-of-2 depths.
    localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);
    localparam logic          CLR_EN    = (CLEAR_ON_RST != 32'sd0);

    logic [WIDTH-1:0] mem_r [DEPTH];

    bram_state_e      state_r;
    logic [AW-1:0]    clr_ptr_r;
    logic             init_done_r;
    logic             coll_r;
    logic [WIDTH-1:0] q0_r;
    logic [WIDTH-1:0] q1_r;

    logic             ready_s;
    logic             in_rng0_s;
    logic             in_rng1_s;
    logic             same_addr_s;
    logic             wr0_s;
    logic             wr1_s;
    logic             both_wr_same_s;
    logic [WIDTH-1:0] old0_s;
    logic [WIDTH-1:0] old1_s;
    logic [WIDTH-1:0] m0_s;
    logic [WIDTH-1:0] m1_s;
    logic [WIDTH-1:0] mboth_s;
    logic [WIDTH-1:0] new0_s;
    logic [WIDTH-1:0] new1_s;
    logic [WIDTH-1:0] q0_nxt_s;
    logic [WIDTH-1:0] q1_nxt_s;

    // Next value of a port's read register for the configured read-during-write mode.
    function automatic logic [WIDTH-1:0] rdw_next(
        input logic             ce,
        input logic             we,
        input logic             in_rng,
        input logic [WIDTH-1:0] old_word,
        input logic [WIDTH-1:0] new_word,
        input logic [WIDTH-1:0] cur_word
    );
        logic [WIDTH-1:0] nxt;
        nxt = cur_word;
        if (ce && we) begin
            case (RDW_MODE)
                RDW_WRITE_FIRST: nxt = in_rng ? new_word : {WIDTH{1'b0}};
                RDW_READ_FIRST:  nxt = old_word;
                RDW_NO_CHANGE:   nxt = cur_word;
                default:         nxt = cur_word;
            endcase
        end else if (ce) begin
            nxt = old_word;
        end else begin
            nxt = cur_word;
        end
        return nxt;
    endfunction

    assign ready_s     = (state_r == ST_READY);
    assign in_rng0_s   = ({1'b0, A0} < DEPTH_EXT);
    assign in_rng1_s   = ({1'b0, A1} < DEPTH_EXT);
    assign same_addr_s = (A0 == A1);

    // Address decode, old-word fetch and masked-merge of the write data.
    always_comb begin
        wr0_s          = ready_s & CE0 & WE0 & in_rng0_s;
        wr1_s          = ready_s & CE1 & WE1 & in_rng1_s;
        both_wr_same_s = wr0_s & wr1_s & same_addr_s;

        if (in_rng0_s) begin
            old0_s = mem_r[A0];
        end else begin
            old0_s = {WIDTH{1'b0}};
        end
        if (in_rng1_s) begin
            old1_s = mem_r[A1];
        end else begin
            old1_s = {WIDTH{1'b0}};
        end

        m0_s    = WIDTH'(merge_word(MERGE_W'(old0_s), MERGE_W'(D0), MERGE_W'(WEM0)));
        m1_s    = WIDTH'(merge_word(MERGE_W'(old1_s), MERGE_W'(D1), MERGE_W'(WEM1)));
        // Port 1 bits first, then port 0 bits on top: port 0 wins on overlap.
        mboth_s = WIDTH'(merge_word(MERGE_W'(m1_s), MERGE_W'(D0), MERGE_W'(WEM0)));

        if (both_wr_same_s) begin
            new0_s = mboth_s;
            new1_s = mboth_s;
        end else begin
            new0_s = m0_s;
            new1_s = m1_s;
        end

        q0_nxt_s = rdw_next(CE0, WE0, in_rng0_s, old0_s, new0_s, q0_r);
        q1_nxt_s = rdw_next(CE1, WE1, in_rng1_s, old1_s, new1_s, q1_r);
    end

    // Array writes: zero fill while clearing, masked port writes once ready.
    // The array contents themselves are never touched by RST.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (state_r == ST_CLEAR) begin
                if (CLR_EN) begin
                    mem_r[clr_ptr_r] <= {WIDTH{1'b0}};
                end
            end else begin
                if (wr1_s) begin
                    mem_r[A1] <= new1_s;
                end
                if (wr0_s) begin
                    mem_r[A0] <= new0_s;
                end
            end
        end
    end

    // Clear sequencer, INIT_DONE and collision flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= ST_CLEAR;
            clr_ptr_r   <= {AW{1'b0}};
            init_done_r <= 1'b0;
            coll_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    coll_r <= 1'b0;
                    if (!CLR_EN || (clr_ptr_r == LAST_PTR)) begin
                        state_r     <= ST_READY;
                        init_done_r <= 1'b1;
                    end else begin
                        clr_ptr_r   <= clr_ptr_r + AW'(1);
                        init_done_r <= 1'b0;
                    end
                end
                ST_READY: begin
                    init_done_r <= 1'b1;
                    coll_r      <= CE0 & CE1 & same_addr_s & (WE0 | WE1);
                end
                default: begin
                    state_r     <= ST_CLEAR;
                    clr_ptr_r   <= {AW{1'b0}};
                    init_done_r <= 1'b0;
                    coll_r      <= 1'b0;
                end
            endcase
        end
    end

    // Array-side read registers; held at zero until the array is usable.
    always_ff @(posedge CLK) begin
        if (RST) begin
            q0_r <= {WIDTH{1'b0}};
            q1_r <= {WIDTH{1'b0}};
        end else if (!ready_s) begin
            q0_r <= {WIDTH{1'b0}};
            q1_r <= {WIDTH{1'b0}};
        end else begin
            q0_r <= q0_nxt_s;
            q1_r <= q1_nxt_s;
        end
    end

    bram_out_stage #(.WIDTH(WIDTH), .OUT_REG(OUT_REG)) u_out0 (
        .CLK (CLK),
        .RST (RST),
        .d   (q0_r),
        .q   (Q0)
    );

    bram_out_stage #(.WIDTH(WIDTH), .OUT_REG(OUT_REG)) u_out1 (
        .CLK (CLK),
        .RST (RST),
        .d   (q1_r),
        .q   (Q1)
    );

    assign INIT_DONE = init_done_r;
    assign COLL      = coll_r;

endmodule

// File: tb/tb_bram_tdp_param.sv
// Scoreboard bench for bram_tdp_param: three 2048x8 instances sharing stimulus
// (write-first / read-first / no-change) plus a 1000x16 instance with OUT_REG=1.
module tb_bram_tdp_param;
    import bram_pkg::*;

    logic CLK;
    logic RST;

    // Shared stimulus for the three 2048x8 instances
    logic [10:0] a0, a1;
    logic [7:0]  d0, d1, wem0, wem1;
    logic        we0, we1, ce0, ce1;
    logic [7:0]  q0_wf, q1_wf, q0_rf, q1_rf, q0_nc, q1_nc;
    logic        done_wf, done_rf, done_nc, coll_wf, coll_rf, coll_nc;

    // 1000x16 OUT_REG instance
    logic [9:0]  oa0, oa1;
    logic [15:0] od0, od1, owem0, owem1;
    logic        owe0, owe1, oce0, oce1;
    logic [15:0] oq0, oq1;
    logic        odone, ocoll;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int rel, rel2, rel3;

    typedef struct {
        int          due;
        int          dut;
        int          kind;   // 0=Q0 1=Q1 2=INIT_DONE 3=COLL
        logic [15:0] exp;
        string       name;
    } exp_t;
    exp_t sb_q[$];

    bram_tdp_param #(.DEPTH(2048), .WIDTH(8), .OUT_REG(0), .RDW_MODE(RDW_WRITE_FIRST), .CLEAR_ON_RST(1)) u_wf (
        .CLK(CLK), .RST(RST),
        .A0(a0), .D0(d0), .WEM0(wem0), .WE0(we0), .CE0(ce0), .Q0(q0_wf),
        .A1(a1), .D1(d1), .WEM1(wem1), .WE1(we1), .CE1(ce1), .Q1(q1_wf),
        .INIT_DONE(done_wf), .COLL(coll_wf));

    bram_tdp_param #(.DEPTH(2048), .WIDTH(8), .OUT_REG(0), .RDW_MODE(RDW_READ_FIRST), .CLEAR_ON_RST(1)) u_rf (
        .CLK(CLK), .RST(RST),
        .A0(a0), .D0(d0), .WEM0(wem0), .WE0(we0), .CE0(ce0), .Q0(q0_rf),
        .A1(a1), .D1(d1), .WEM1(wem1), .WE1(we1), .CE1(ce1), .Q1(q1_rf),
        .INIT_DONE(done_rf), .COLL(coll_rf));

    bram_tdp_param #(.DEPTH(2048), .WIDTH(8), .OUT_REG(0), .RDW_MODE(RDW_NO_CHANGE), .CLEAR_ON_RST(1)) u_nc (
        .CLK(CLK), .RST(RST),
        .A0(a0), .D0(d0), .WEM0(wem0), .WE0(we0), .CE0(ce0), .Q0(q0_nc),
        .A1(a1), .D1(d1), .WEM1(wem1), .WE1(we1), .CE1(ce1), .Q1(q1_nc),
        .INIT_DONE(done_nc), .COLL(coll_nc));

    bram_tdp_param #(.DEPTH(1000), .WIDTH(16), .OUT_REG(1), .RDW_MODE(RDW_WRITE_FIRST), .CLEAR_ON_RST(1)) u_or (
        .CLK(CLK), .RST(RST),
        .A0(oa0), .D0(od0), .WEM0(owem0), .WE0(owe0), .CE0(oce0), .Q0(oq0),
        .A1(oa1), .D1(od1), .WEM1(owem1), .WE1(owe1), .CE1(oce1), .Q1(oq1),
        .INIT_DONE(odone), .COLL(ocoll));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Cycle counter: value n is seen between edge n and edge n+1
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [15:0] obs_of(input int dut, input int kind);
        logic [15:0] v;
        v = 16'h0000;
        case (dut)
            0: case (kind) 0: v = {8'h00, q0_wf}; 1: v = {8'h00, q1_wf}; 2: v = {15'd0, done_wf}; default: v = {15'd0, coll_wf}; endcase
            1: case (kind) 0: v = {8'h00, q0_rf}; 1: v = {8'h00, q1_rf}; 2: v = {15'd0, done_rf}; default: v = {15'd0, coll_rf}; endcase
            2: case (kind) 0: v = {8'h00, q0_nc}; 1: v = {8'h00, q1_nc}; 2: v = {15'd0, done_nc}; default: v = {15'd0, coll_nc}; endcase
            default: case (kind) 0: v = oq0; 1: v = oq1; 2: v = {15'd0, odone}; default: v = {15'd0, ocoll}; endcase
        endcase
        return v;
    endfunction

    // Monitor: compares every scoreboard entry that falls due in this cycle
    always @(negedge CLK) begin : monitor
        int          i;
        logic [15:0] obs;
        i = 0;
        while (i < sb_q.size()) begin
            if (sb_q[i].due <= cyc) begin
                obs = obs_of(sb_q[i].dut, sb_q[i].kind);
                checks++;
                if (sb_q[i].due < cyc) begin
                    errors++;
                    $display("FAIL %s: entry missed its cycle (due %0d, now %0d)", sb_q[i].name, sb_q[i].due, cyc);
                end else if (obs !== sb_q[i].exp) begin
                    errors++;
                    $display("FAIL %s: dut%0d sig%0d got %h, expected %h (cycle %0d)",
                             sb_q[i].name, sb_q[i].dut, sb_q[i].kind, obs, sb_q[i].exp, cyc);
                end
                sb_q.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic sb_push(input int dut, input int kind, input int lat, input logic [15:0] v, input string nm);
        exp_t e;
        e.due  = cyc + lat;
        e.dut  = dut;
        e.kind = kind;
        e.exp  = v;
        e.name = nm;
        sb_q.push_back(e);
    endtask

    // Same expectation on all three 2048x8 instances
    task automatic exp3(input int kind, input logic [15:0] v, input string nm);
        for (int k = 0; k < 3; k++) sb_push(k, kind, 1, v, nm);
    endtask

    task automatic p0(input logic ce, input logic we, input logic [10:0] a, input logic [7:0] d, input logic [7:0] wem);
        ce0 = ce; we0 = we; a0 = a; d0 = d; wem0 = wem;
    endtask

    task automatic p1(input logic ce, input logic we, input logic [10:0] a, input logic [7:0] d, input logic [7:0] wem);
        ce1 = ce; we1 = we; a1 = a; d1 = d; wem1 = wem;
    endtask

    task automatic op0(input logic ce, input logic we, input logic [9:0] a, input logic [15:0] d);
        oce0 = ce; owe0 = we; oa0 = a; od0 = d; owem0 = 16'hFFFF;
    endtask

    task automatic op1(input logic ce, input logic we, input logic [9:0] a, input logic [15:0] d);
        oce1 = ce; owe1 = we; oa1 = a; od1 = d; owem1 = 16'hFFFF;
    endtask

    task automatic idle();
        p0(1'b0, 1'b0, 11'd0, 8'h00, 8'h00);
        p1(1'b0, 1'b0, 11'd0, 8'h00, 8'h00);
        op0(1'b0, 1'b0, 10'd0, 16'h0000);
        op1(1'b0, 1'b0, 10'd0, 16'h0000);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        RST = 1'b1;
        idle();
        repeat (3) tick();

        // Reset state of every observable output
        for (int d = 0; d < 4; d++)
            for (int k = 0; k < 4; k++) sb_push(d, k, 0, 16'h0000, "reset_state");

        // Release reset: INIT_DONE rises DEPTH cycles later
        RST = 1'b0;
        rel = cyc;
        for (int d = 0; d < 3; d++) begin
            sb_push(d, 2, 2047, 16'h0000, "init_done_before_2048");
            sb_push(d, 2, 2048, 16'h0001, "init_done_at_2048");
        end
        sb_push(3, 2, 999, 16'h0000, "init_done_before_1000");
        sb_push(3, 2, 1000, 16'h0001, "init_done_at_1000");

        // Accesses during the clear must be ignored
        repeat (10) tick();
        p0(1'b1, 1'b1, 11'd0, 8'hFF, 8'hFF);
        p1(1'b1, 1'b1, 11'd0, 8'hFF, 8'hFF);
        op0(1'b1, 1'b1, 10'd4, 16'hBEEF);
        sb_push(0, 0, 1, 16'h0000, "q0_held_in_clear");
        sb_push(0, 1, 1, 16'h0000, "q1_held_in_clear");
        sb_push(0, 3, 1, 16'h0000, "coll_ignored_in_clear");
        tick();
        idle();
        while (cyc < rel + 2048) tick();

        // Masked writes to addr 5
        p0(1'b1, 1'b1, 11'd5, 8'hFF, 8'hFF);
        sb_push(0, 0, 1, 16'h00FF, "wf_write_ff"); sb_push(1, 0, 1, 16'h0000, "rf_write_ff"); sb_push(2, 0, 1, 16'h0000, "nc_write_ff");
        tick();
        p0(1'b1, 1'b1, 11'd5, 8'h0F, 8'hF0);
        sb_push(0, 0, 1, 16'h000F, "wf_mask_f0"); sb_push(1, 0, 1, 16'h00FF, "rf_mask_f0"); sb_push(2, 0, 1, 16'h0000, "nc_mask_f0");
        tick();
        p0(1'b1, 1'b1, 11'd5, 8'hAA, 8'h00);
        sb_push(0, 0, 1, 16'h000F, "wf_mask_00"); sb_push(1, 0, 1, 16'h000F, "rf_mask_00"); sb_push(2, 0, 1, 16'h0000, "nc_mask_00");
        tick();
        p0(1'b1, 1'b0, 11'd5, 8'h00, 8'h00);
        p1(1'b1, 1'b0, 11'd5, 8'h00, 8'h00);
        exp3(0, 16'h000F, "read5_q0"); exp3(1, 16'h000F, "read5_q1");
        sb_push(0, 3, 1, 16'h0000, "coll_read_read");
        tick();

        // Cleared locations, including the addr written during the clear
        p0(1'b1, 1'b0, 11'd0, 8'h00, 8'h00);
        p1(1'b1, 1'b0, 11'd1023, 8'h00, 8'h00);
        sb_push(0, 0, 1, 16'h0000, "clear_addr0"); sb_push(0, 1, 1, 16'h0000, "clear_addr1023");
        tick();
        p0(1'b1, 1'b0, 11'd5, 8'h00, 8'h00);
        p1(1'b1, 1'b0, 11'd5, 8'h00, 8'h00);
        tick();
        p0(1'b1, 1'b0, 11'd2047, 8'h00, 8'h00);
        p1(1'b1, 1'b0, 11'd2047, 8'h00, 8'h00);
        sb_push(0, 0, 1, 16'h0000, "clear_addr2047_p0"); sb_push(0, 1, 1, 16'h0000, "clear_addr2047_p1");
        tick();

        // Read-during-write modes at addr 9
        p1(1'b0, 1'b0, 11'd0, 8'h00, 8'h00);
        p0(1'b1, 1'b1, 11'd9, 8'h11, 8'hFF);
        tick();
        p0(1'b1, 1'b0, 11'd5, 8'h00, 8'h00);
        exp3(0, 16'h000F, "read5_before_rdw");
        tick();
        p0(1'b1, 1'b1, 11'd9, 8'h22, 8'hFF);
        sb_push(0, 0, 1, 16'h0022, "rdw_write_first");
        sb_push(1, 0, 1, 16'h0011, "rdw_read_first");
        sb_push(2, 0, 1, 16'h000F, "rdw_no_change");
        tick();
        p0(1'b1, 1'b0, 11'd9, 8'h00, 8'h00);
        exp3(0, 16'h0022, "read9_after_rdw");
        tick();

        // Dual write collision at addr 100
        p0(1'b1, 1'b1, 11'd100, 8'hAA, 8'h0F);
        p1(1'b1, 1'b1, 11'd100, 8'h55, 8'hFF);
        sb_push(0, 3, 1, 16'h0001, "coll_dual_write");
        tick();
        idle();
        sb_push(0, 3, 1, 16'h0000, "coll_one_cycle");
        tick();
        p0(1'b1, 1'b0, 11'd100, 8'h00, 8'h00);
        exp3(0, 16'h005A, "dual_write_merge");
        tick();
        p0(1'b1, 1'b1, 11'd100, 8'hC3, 8'hFF);
        p1(1'b1, 1'b0, 11'd100, 8'h00, 8'h00);
        sb_push(0, 1, 1, 16'h005A, "write_read_gets_old");
        sb_push(0, 3, 1, 16'h0001, "coll_write_read");
        tick();
        p0(1'b1, 1'b0, 11'd100, 8'h00, 8'h00);
        p1(1'b1, 1'b0, 11'd100, 8'h00, 8'h00);
        sb_push(0, 0, 1, 16'h00C3, "read100_p0"); sb_push(0, 1, 1, 16'h00C3, "read100_p1");
        sb_push(0, 3, 1, 16'h0000, "coll_after_reads");
        tick();

        // Independent writes to different addresses; then CE=0 holds
        p0(1'b1, 1'b1, 11'd200, 8'h01, 8'hFF);
        p1(1'b1, 1'b1, 11'd201, 8'h02, 8'hFF);
        sb_push(0, 0, 1, 16'h0001, "wf_q0_diff"); sb_push(0, 1, 1, 16'h0002, "wf_q1_diff");
        sb_push(0, 3, 1, 16'h0000, "coll_diff_addr");
        tick();
        p0(1'b1, 1'b0, 11'd201, 8'h00, 8'h00);
        p1(1'b1, 1'b0, 11'd200, 8'h00, 8'h00);
        sb_push(0, 0, 1, 16'h0002, "read201"); sb_push(0, 1, 1, 16'h0001, "read200");
        tick();
        p0(1'b0, 1'b1, 11'd201, 8'hFF, 8'hFF);
        p1(1'b0, 1'b0, 11'd0, 8'h00, 8'h00);
        sb_push(0, 0, 1, 16'h0002, "ce0_low_hold"); sb_push(0, 1, 1, 16'h0001, "ce1_low_hold");
        tick();
        p0(1'b1, 1'b0, 11'd201, 8'h00, 8'h00);
        exp3(0, 16'h0002, "ce0_low_no_write");
        tick();
        idle();

        // OUT_REG instance: fill 0..3, drop an out-of-range write
        for (int i = 0; i < 4; i++) begin
            op0(1'b1, 1'b1, 10'(i), 16'h1000 + 16'(i));
            if (i == 0) op1(1'b1, 1'b1, 10'd1010, 16'hFFFF);
            else        op1(1'b0, 1'b0, 10'd0, 16'h0000);
            tick();
        end
        op1(1'b0, 1'b0, 10'd0, 16'h0000);
        op0(1'b1, 1'b0, 10'd0, 16'h0000);
        op1(1'b1, 1'b0, 10'd3, 16'h0000);
        sb_push(3, 0, 1, 16'h1003, "outreg_not_yet");
        sb_push(3, 0, 2, 16'h1000, "outreg_addr0");
        sb_push(3, 1, 2, 16'h1003, "outreg_p1_addr3");
        tick();
        op0(1'b1, 1'b0, 10'd1, 16'h0000);
        op1(1'b1, 1'b0, 10'd1010, 16'h0000);
        sb_push(3, 0, 2, 16'h1001, "outreg_addr1");
        sb_push(3, 1, 2, 16'h0000, "outreg_out_of_range");
        tick();
        op1(1'b0, 1'b0, 10'd0, 16'h0000);
        op0(1'b1, 1'b0, 10'd2, 16'h0000);
        sb_push(3, 0, 2, 16'h1002, "outreg_addr2");
        tick();
        op0(1'b1, 1'b0, 10'd4, 16'h0000);
        sb_push(3, 0, 2, 16'h0000, "outreg_clear_ignored_write");
        tick();
        op0(1'b1, 1'b0, 10'd3, 16'h0000);
        sb_push(3, 0, 2, 16'h1003, "outreg_addr3");
        tick();
        idle();
        repeat (3) tick();

        // Mid-operation reset, then a reset during the clear at ptr ~700
        RST = 1'b1;
        tick();
        RST = 1'b0;
        rel2 = cyc;
        for (int d = 0; d < 4; d++)
            for (int k = 0; k < 3; k++) sb_push(d, k, 0, 16'h0000, "mid_op_reset");
        while (cyc < rel2 + 700) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        rel3 = cyc;
        sb_push(0, 2, 0, 16'h0000, "mid_clear_reset_done");
        sb_push(0, 0, 0, 16'h0000, "mid_clear_reset_q0");
        sb_push(0, 2, 2047, 16'h0000, "restart_done_before_2048");
        sb_push(0, 2, 2048, 16'h0001, "restart_done_at_2048");
        sb_push(3, 2, 999, 16'h0000, "restart_or_before_1000");
        sb_push(3, 2, 1000, 16'h0001, "restart_or_at_1000");
        while (cyc < rel3 + 2048) tick();
        p0(1'b1, 1'b0, 11'd100, 8'h00, 8'h00);
        p1(1'b1, 1'b0, 11'd9, 8'h00, 8'h00);
        sb_push(0, 0, 1, 16'h0000, "recleared_addr100");
        sb_push(0, 1, 1, 16'h0000, "recleared_addr9");
        tick();
        idle();

        // Drain the scoreboard with a bounded wait
        for (int n = 0; n < 10 && sb_q.size() != 0; n++) tick();
        while (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s: never compared (due %0d)", sb_q[0].name, sb_q[0].due);
            void'(sb_q.pop_front());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
